// File: rtl/rsa2048_word_packer.sv
// Width converter between a 32-bit bus and 2048-bit RSA operand/result ports; RSA_PACK_BSWAP_EN reverses byte order within each word.
// Latency: last word accepted -> op_valid next cycle; result captured -> first word next cycle, then one word per cycle.
// Backpressure: single-buffered; s_ready low while an operand is held, r_ready low while a result drains.
module rsa2048_word_packer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 2048
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [OP_W-1:0]   op_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [OP_W-1:0]   r_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              len_err
);

    localparam int WORDS = OP_W / DATA_W;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    logic [DATA_W-1:0] s_word;
    logic [DATA_W-1:0] m_word;

`ifdef RSA_PACK_BSWAP_EN
    function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            r[8*b +: 8] = w[DATA_W-8-8*b +: 8];
        end
        return r;
    endfunction

    assign s_word = bswap(s_data);
    assign m_data = bswap(m_word);
`else
    assign s_word = s_data;
    assign m_data = m_word;
`endif

    // ------------------------------------------------------------------
    // Pack path
    // ------------------------------------------------------------------
    typedef enum logic {P_FILL, P_HOLD} p_state_t;

    p_state_t         p_state, p_next;
    logic [CNT_W-1:0] wr_cnt;
    logic             s_fire;
    logic             op_fire;
    logic             p_done;

    assign s_fire  = s_valid && s_ready;
    assign op_fire = op_valid && op_ready;
    assign p_done  = s_fire && (s_last || (wr_cnt == LAST_IDX));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            p_state <= P_FILL;
        end else begin
            p_state <= p_next;
        end
    end

    always_comb begin
        p_next = p_state;
        if (flush) begin
            p_next = P_FILL;
        end else begin
            case (p_state)
                P_FILL:  if (p_done)  p_next = P_HOLD;
                P_HOLD:  if (op_fire) p_next = P_FILL;
                default: p_next = P_FILL;
            endcase
        end
    end

    // op_data is zero whenever filling starts (reset, flush, or cleared on
    // hand-off), so words beyond an early s_last are already zero-filled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_ready  <= 1'b0;
            wr_cnt   <= '0;
            op_valid <= 1'b0;
            op_data  <= '0;
            len_err  <= 1'b0;
        end else begin
            s_ready <= (p_next == P_FILL);
            if (flush) begin
                wr_cnt   <= '0;
                op_valid <= 1'b0;
                op_data  <= '0;
                len_err  <= 1'b0;
            end else begin
                if (s_fire) begin
                    op_data[wr_cnt*DATA_W +: DATA_W] <= s_word;
                    wr_cnt <= p_done ? '0 : wr_cnt + 1'b1;
                end
                if (p_done) begin
                    op_valid <= 1'b1;
                    // early s_last, or final word arriving without s_last
                    if (s_last != (wr_cnt == LAST_IDX)) begin
                        len_err <= 1'b1;
                    end
                end else if (op_fire) begin
                    op_valid <= 1'b0;
                    op_data  <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Unpack path
    // ------------------------------------------------------------------
    typedef enum logic {U_IDLE, U_SEND} u_state_t;

    u_state_t         u_state, u_next;
    logic [CNT_W-1:0] rd_cnt;
    logic [OP_W-1:0]  res_sh;
    logic             r_fire;
    logic             m_fire;

    assign r_fire  = r_valid && r_ready;
    assign m_fire  = m_valid && m_ready;
    assign m_valid = (u_state == U_SEND);
    assign m_last  = m_valid && (rd_cnt == LAST_IDX);
    assign m_word  = res_sh[DATA_W-1:0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            u_state <= U_IDLE;
        end else begin
            u_state <= u_next;
        end
    end

    always_comb begin
        u_next = u_state;
        if (flush) begin
            u_next = U_IDLE;
        end else begin
            case (u_state)
                U_IDLE:  if (r_fire) u_next = U_SEND;
                U_SEND:  if (m_fire && (rd_cnt == LAST_IDX)) u_next = U_IDLE;
                default: u_next = U_IDLE;
            endcase
        end
    end

    // Word j always sits in the low slice; each accepted word shifts the next one down.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ready <= 1'b0;
            rd_cnt  <= '0;
            res_sh  <= '0;
        end else begin
            r_ready <= (u_next == U_IDLE);
            if (flush) begin
                rd_cnt <= '0;
                res_sh <= '0;
            end else if (r_fire) begin
                rd_cnt <= '0;
                res_sh <= r_data;
            end else if (m_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                res_sh <= res_sh >> DATA_W;
            end
        end
    end

endmodule

// File: tb/tb_rsa2048_word_packer.sv
// Scoreboard bench for rsa2048_word_packer: expected operands and words are queued when driven and checked when the DUT hands them off.
module tb_rsa2048_word_packer;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          op_valid;
    logic          op_ready = 1'b1;
    logic [2047:0] op_data;
    logic          r_valid = 1'b0;
    logic          r_ready;
    logic [2047:0] r_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   m_data;
    logic          m_last;
    logic          len_err;

    rsa2048_word_packer dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .len_err(len_err)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_err = 0;

    logic [2047:0] op_q[$];
    logic [32:0]   m_q[$];
    logic [2047:0] pk_exp = '0;
    int            pk_k = 0;
    logic [2047:0] mon_e;
    logic [32:0]   mon_m;
    logic [2047:0] snap;
    logic [2047:0] rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef RSA_PACK_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic l);
        int   n = 0;
        logic acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!acc && n < 200) begin
            @(negedge HCLK);
            acc = s_ready;
            n++;
        end
        chk("s_ready_timeout", {63'd0, acc}, 64'd1);
        @(posedge HCLK);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (acc) begin
            pk_exp[32*pk_k +: 32] = sw(d);
            if (l || pk_k == 63) begin
                op_q.push_back(pk_exp);
                pk_exp = '0;
                pk_k   = 0;
            end else begin
                pk_k++;
            end
        end
    endtask

    task automatic cap_result(input logic [2047:0] d);
        int   n = 0;
        logic acc = 1'b0;
        r_valid = 1'b1;
        r_data  = d;
        while (!acc && n < 200) begin
            @(negedge HCLK);
            acc = r_ready;
            n++;
        end
        chk("r_ready_timeout", {63'd0, acc}, 64'd1);
        @(posedge HCLK);
        #1;
        r_valid = 1'b0;
        if (acc) begin
            for (int j = 0; j < 64; j++) begin
                m_q.push_back({(j == 63), sw(d[32*j +: 32])});
            end
        end
    endtask

    task automatic wait_op_drain();
        int n = 0;
        while (op_q.size() != 0 && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        chk("op_drain", 64'(op_q.size()), 64'd0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic drop_partial();
        pk_exp = '0;
        pk_k   = 0;
        m_q.delete();
    endtask

    // Scoreboard monitor: transfers complete on the next rising edge.
    always @(negedge HCLK) begin
        if (HRESETn && !flush) begin
            if (m_q.size() != 0) chk("r_ready_busy", {63'd0, r_ready}, 64'd0);
            if (op_valid && op_ready) begin
                chk("op_expected", {63'd0, op_q.size() != 0}, 64'd1);
                if (op_q.size() != 0) begin
                    mon_e = op_q.pop_front();
                    chk("op_data_eq", {63'd0, op_data == mon_e}, 64'd1);
                    chk("op_data_lo", op_data[63:0], mon_e[63:0]);
                end
            end
            if (m_valid && m_ready) begin
                chk("m_expected", {63'd0, m_q.size() != 0}, 64'd1);
                if (m_q.size() != 0) begin
                    mon_m = m_q.pop_front();
                    chk("m_data", {32'd0, m_data}, {32'd0, mon_m[31:0]});
                    chk("m_last", {63'd0, m_last}, {63'd0, mon_m[32]});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_s_ready"},  {63'd0, s_ready},  64'd0);
        chk({tag, "_op_valid"}, {63'd0, op_valid}, 64'd0);
        chk({tag, "_op_data"},  {63'd0, op_data == '0}, 64'd1);
        chk({tag, "_r_ready"},  {63'd0, r_ready},  64'd0);
        chk({tag, "_m_valid"},  {63'd0, m_valid},  64'd0);
        chk({tag, "_m_data"},   {32'd0, m_data},   64'd0);
        chk({tag, "_m_last"},   {63'd0, m_last},   64'd0);
        chk({tag, "_len_err"},  {63'd0, len_err},  64'd0);
    endtask

    initial begin
        #3;
        chk_reset_values("rst");
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // T1: full 64-word operand
        for (int k = 0; k < 64; k++) begin
            if (k == 63) chk("t1_op_valid_pre", {63'd0, op_valid}, 64'd0);
            send_word(32'h1000_0000 + k, k == 63);
        end
        chk("t1_op_valid_lat", {63'd0, op_valid}, 64'd1);
        chk("t1_op_lo", {32'd0, op_data[31:0]}, {32'd0, sw(32'h1000_0000)});
        chk("t1_op_hi", {32'd0, op_data[2047:2016]}, {32'd0, sw(32'h1000_003F)});
        chk("t1_len_err", {63'd0, len_err}, 64'd0);
        wait_op_drain();

        // T2: operand held under backpressure
        op_ready = 1'b0;
        for (int k = 0; k < 64; k++) send_word(32'h2000_0000 + k, k == 63);
        snap = op_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge HCLK);
            chk("t2_s_ready_low", {63'd0, s_ready}, 64'd0);
            chk("t2_op_stable", {63'd0, op_data == snap}, 64'd1);
        end
        @(posedge HCLK);
        #1;
        op_ready = 1'b1;
        @(posedge HCLK);
        #1;
        chk("t2_s_ready_back", {63'd0, s_ready}, 64'd1);
        chk("t2_op_valid_clr", {63'd0, op_valid}, 64'd0);
        chk("t2_op_data_clr", {63'd0, op_data == '0}, 64'd1);
        chk("t2_drained", 64'(op_q.size()), 64'd0);

        // T3: early s_last after 4 words
        for (int k = 0; k < 4; k++) send_word(32'(k + 1), k == 3);
        chk("t3_len_err", {63'd0, len_err}, 64'd1);
        chk("t3_op_w3", {32'd0, op_data[127:96]}, {32'd0, sw(32'd4)});
        chk("t3_op_w4", {32'd0, op_data[159:128]}, 64'd0);
        wait_op_drain();
        flush = 1'b1;
        @(posedge HCLK);
        #1;
        flush = 1'b0;
        chk("t3_len_err_flush", {63'd0, len_err}, 64'd0);

        // T4: unpack with m_ready toggling
        for (int j = 0; j < 64; j++) rd[32*j +: 32] = 32'hA5A5_0000 | 32'(j);
        m_ready = 1'b0;
        cap_result(rd);
        for (int c = 0; c < 400 && m_q.size() != 0; c++) begin
            @(posedge HCLK);
            #1;
            m_ready = ~m_ready;
        end
        m_ready = 1'b0;
        chk("t4_burst_done", 64'(m_q.size()), 64'd0);
        chk("t4_m_valid_end", {63'd0, m_valid}, 64'd0);
        chk("t4_r_ready_end", {63'd0, r_ready}, 64'd1);

        // T5a: flush with both paths mid-operation
        for (int j = 0; j < 64; j++) rd[32*j +: 32] = 32'h5A00_0000 + 32'(j * 3);
        cap_result(rd);
        for (int k = 0; k < 20; k++) send_word(32'h3000_0000 + k, 1'b0);
        m_ready = 1'b1;
        repeat (10) @(posedge HCLK);
        #1;
        m_ready = 1'b0;
        flush = 1'b1;
        chk("t5_unpacked_10", 64'(m_q.size()), 64'd54);
        drop_partial();
        @(posedge HCLK);
        #1;
        flush = 1'b0;
        chk("t5_op_valid", {63'd0, op_valid}, 64'd0);
        chk("t5_m_valid", {63'd0, m_valid}, 64'd0);
        chk("t5_op_data", {63'd0, op_data == '0}, 64'd1);
        chk("t5_r_ready", {63'd0, r_ready}, 64'd1);
        for (int k = 0; k < 64; k++) send_word(32'h4000_0000 ^ 32'(k * 32'h0101), k == 63);
        chk("t5_fresh_len_err", {63'd0, len_err}, 64'd0);
        wait_op_drain();

        // T5b: reset pulse with both paths mid-operation
        cap_result(rd);
        for (int k = 0; k < 20; k++) send_word(32'h6000_0000 + k, 1'b0);
        m_ready = 1'b1;
        repeat (10) @(posedge HCLK);
        #1;
        m_ready = 1'b0;
        HRESETn = 1'b0;
        drop_partial();
        #1;
        chk_reset_values("t5_rst");
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // T6: byte order and round trip
        op_ready = 1'b0;
        send_word(32'h1122_3344, 1'b1);
`ifdef RSA_PACK_BSWAP_EN
        chk("t6_op_lo", {32'd0, op_data[31:0]}, 64'h4433_2211);
`else
        chk("t6_op_lo", {32'd0, op_data[31:0]}, 64'h1122_3344);
`endif
        snap = op_data;
        op_ready = 1'b1;
        wait_op_drain();
        cap_result(snap);
        chk("t6_round_trip", {32'd0, m_data}, 64'h1122_3344);
        m_ready = 1'b1;
        for (int c = 0; c < 200 && m_q.size() != 0; c++) @(posedge HCLK);
        #1;
        m_ready = 1'b0;
        chk("t6_drained", 64'(m_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
